modexp_wb_regs_narrow: RTL and testbench
========================================

// Module: modexp_wb_regs_narrow
// PURPOSE
//  Wishbone slave register front-end for a wide modular-exponentiation core (RSA path).
//  Bus data width is narrower than operand width: each operand is a multi-word register bank.
//  Adds start/abort control, a sticky status register, an interrupt, and busy-write protection.
//  Sits between the system Wishbone bus and the modexp core, which is instantiated by the parent.
// PARAMETERS
//  OPW  1024  operand/result width in bits; must be a multiple of DW
//  DW   32    Wishbone data width in bits; must be a multiple of 8
//  NW   OPW/DW  words per operand (localparam)
//  AW   $clog2(4*NW+3)  word-address width (localparam)
// PORTS
//  clk           in   1      single clock; all logic is on the rising edge
//  rst           in   1      synchronous, active-high reset
//  cyc           in   1      Wishbone cycle
//  stb           in   1      Wishbone strobe
//  we            in   1      1 = write, 0 = read
//  addr          in   AW     word address
//  sel           in   DW/8   byte enables for writes
//  data_in       in   DW     write data
//  data_out      out  DW     read data, registered, valid when ack=1
//  ack           out  1      one-cycle acknowledge
//  irq           out  1      level interrupt; registered
//  core_base     out  OPW    base operand to the core
//  core_exp      out  OPW    exponent to the core
//  core_mod      out  OPW    modulus to the core
//  core_start    out  1      one-cycle start pulse
//  core_abort    out  1      one-cycle abort pulse
//  core_result   in   OPW    core result; valid in the cycle core_done=1
//  core_done     in   1      one-cycle completion pulse
// BEHAVIOUR
//  Address map (word addresses): BASE[0..NW-1], EXP[NW..2NW-1], MOD[2NW..3NW-1], RESULT[3NW..4NW-1] (RO),
//    CTRL=4NW (W: bit0 start, bit1 abort; reads 0), STATUS=4NW+1, IRQ_EN=4NW+2 (RW, bits[2:0]).
//  Word 0 of each bank is the least-significant DW bits.
//  STATUS bits: [0] busy (RO), [1] done (sticky, W1C), [2] err (sticky, W1C), [3] irq (RO mirror).
//  Reset: all banks, RESULT, IRQ_EN, STATUS 0; data_out 0; ack, irq, core_start, core_abort 0; FSM IDLE.
//  Bus timing: access accepted when cyc&stb&!ack -> ack=1 on the next cycle for exactly one cycle.
//    Back-to-back accesses therefore cost 2 cycles each. Write side effects occur on the accept edge.
//  Byte lanes: only lanes with sel=1 are written, for banks and IRQ_EN.
//  Unmapped addresses: reads return 0; writes are ignored; ack is still given. No error response.
//  FSM: IDLE -> START on an accepted CTRL write with bit0=1.
//    START drives core_start=1 for 1 cycle, then -> RUN. RUN waits for core_done.
//    core_done in START or RUN: capture core_result into RESULT, set done, -> IDLE.
//    core_done while IDLE is ignored.
//    Abort (CTRL bit1=1) in START or RUN: core_abort=1 for 1 cycle, -> IDLE; done not set; RESULT kept.
//    Abort in IDLE: no effect, no pulse.
//    If start and abort are written together, abort wins: in IDLE nothing happens.
//  busy = (state != IDLE).
//  Protection while busy: writes to BASE/EXP/MOD or a start request are ignored and set err.
//    Reads are always allowed. An abort is legal.
//  W1C: writing 1 to done or err clears it. If a set event (capture or err) occurs on the same edge as
//    the clear, set wins.
//  irq = |({err,done,busy_fall} & IRQ_EN) registered, where busy_fall is folded into done.
//    Effectively: irq_next = (done&IRQ_EN[0]) | (err&IRQ_EN[1]); IRQ_EN[2] is reserved, reads as written.
//  Starting a new operation clears done on the START transition.
//  Reset mid-operation returns everything to reset values. The core shares rst; no abort pulse is issued.
// STRUCTURE
//  Shared package modexp_wb_pkg:
//    - state enum (IDLE, START, RUN)
//    - STATUS bit indices
//    - CTRL bit indices
//    - region offset helpers as functions of NW
//  Sub-module modexp_wide_reg_bank #(OPW, DW): OPW-bit register with word-select, byte-lane write,
//    and word readback. Instantiated 3x for BASE/EXP/MOD.
//  RESULT is a plain capture register with a read mux.
// TESTING (bench: OPW=128, DW=32, so NW=4, CTRL=16, STATUS=17, IRQ_EN=18; behavioural core model)
//  Write BASE=4, EXP=13, MOD=497, CTRL=1 -> one core_start pulse; after core_done, RESULT word0=445,
//    STATUS=0x2 (with IRQ_EN=0).
//  IRQ_EN=1, complete an op -> irq=1 the cycle after done sets; write STATUS=0x2 -> done=0, irq=0 next cycle.
//  While busy, write EXP word0=0xFFFF_FFFF -> EXP unchanged, STATUS err=1.
//    CTRL=1 again -> no second core_start.
//  During RUN write CTRL=2 -> core_abort pulse, busy=0, done=0;
//    a later core_done from the model is ignored and RESULT is unchanged.
//  Write BASE word1 with sel=4'b0100, data 0x00AB_0000 over 0x1122_3344 -> word1 reads 0x11AB_3344;
//    read address 20 -> 0.
//  Assert rst during RUN -> every output 0 the next cycle; STATUS reads 0; new start works normally.

Source files
------------

// File: rtl/modexp_wb_pkg.sv
// Shared types and address-map helpers for the modexp
// Wishbone register front-end.
package modexp_wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_ERR  = 2;
   localparam int STAT_IRQ  = 3;

   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;

   localparam int IRQ_DONE = 0;
   localparam int IRQ_ERR  = 1;

   function automatic int exp_off(input int nw);
      return nw;
   endfunction

   function automatic int mod_off(input int nw);
      return 2 * nw;
   endfunction

   function automatic int res_off(input int nw);
      return 3 * nw;
   endfunction

   function automatic int ctrl_addr(input int nw);
      return 4 * nw;
   endfunction

   function automatic int stat_addr(input int nw);
      return 4 * nw + 1;
   endfunction

   function automatic int irqen_addr(input int nw);
      return 4 * nw + 2;
   endfunction

endpackage

// File: rtl/modexp_wide_reg_bank.sv
// Wide operand register written one bus word at a time,
// with per-byte lane enables and word readback.
module modexp_wide_reg_bank #(
   parameter  int OPW = 1024,
   parameter  int DW  = 32,
   localparam int NW  = OPW / DW,
   localparam int WSW = (NW > 1) ? $clog2(NW) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [WSW-1:0]   word_i,
   input  logic [DW/8-1:0]  sel_i,
   input  logic [DW-1:0]    wdata_i,
   output logic [DW-1:0]    rdata_o,
   output logic [OPW-1:0]   value_o
);

   logic [OPW-1:0] val_q, val_d;

   // Merge the selected byte lanes into the addressed word
   always_comb begin
      val_d = val_q;
      if (we_i) begin
         for (int b = 0; b < DW / 8; b++) begin
            if (sel_i[b])
               val_d[int'(word_i) * DW + b * 8 +: 8] = wdata_i[b * 8 +: 8];
         end
      end
   end

   // Operand storage
   always_ff @(posedge clk) begin
      if (rst) val_q <= '0;
      else     val_q <= val_d;
   end

   assign value_o = val_q;
   assign rdata_o = val_q[int'(word_i) * DW +: DW];

endmodule

// File: rtl/modexp_wb_regs_narrow.sv
// Wishbone slave front-end for a wide modexp core: operand
// banks, start/abort control, sticky status and interrupt.
module modexp_wb_regs_narrow
   import modexp_wb_pkg::*;
#(
   parameter  int OPW = 1024,
   parameter  int DW  = 32,
   localparam int NW  = OPW / DW,
   localparam int AW  = $clog2(4 * NW + 3)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cyc,
   input  logic             stb,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [DW/8-1:0]  sel,
   input  logic [DW-1:0]    data_in,
   output logic [DW-1:0]    data_out,
   output logic             ack,
   output logic             irq,
   output logic [OPW-1:0]   core_base,
   output logic [OPW-1:0]   core_exp,
   output logic [OPW-1:0]   core_mod,
   output logic             core_start,
   output logic             core_abort,
   input  logic [OPW-1:0]   core_result,
   input  logic             core_done
);

   localparam int WSW = (NW > 1) ? $clog2(NW) : 1;

   state_e         state_q, state_d;
   logic [OPW-1:0] result_q;
   logic [DW-1:0]  data_out_q, data_out_d;
   logic           ack_q, irq_q, irq_d, abort_q;
   logic           done_q, done_d, err_q, err_d;
   logic [2:0]     irqen_q, irqen_d;

   logic [31:0]    a;
   logic [WSW-1:0] wsel;
   logic           hit_base, hit_exp, hit_mod, hit_res;
   logic           hit_ctrl, hit_stat, hit_irqen;
   logic           acc, wr, busy, start_req, abort_req;
   logic           bank_wr, err_set, go, capture, abort_fire;
   logic [DW-1:0]  base_rd, exp_rd, mod_rd, rd_word;

   assign acc  = cyc & stb & ~ack_q;
   assign wr   = acc & we;
   assign busy = (state_q != ST_IDLE);

   // Address decode into regions and a word index
   always_comb begin
      a         = 32'(addr);
      hit_base  = a < 32'(NW);
      hit_exp   = a >= 32'(exp_off(NW)) && a < 32'(mod_off(NW));
      hit_mod   = a >= 32'(mod_off(NW)) && a < 32'(res_off(NW));
      hit_res   = a >= 32'(res_off(NW)) && a < 32'(ctrl_addr(NW));
      hit_ctrl  = a == 32'(ctrl_addr(NW));
      hit_stat  = a == 32'(stat_addr(NW));
      hit_irqen = a == 32'(irqen_addr(NW));
      wsel      = WSW'(a % 32'(NW));
   end

   assign bank_wr   = wr & ~busy;
   assign start_req = wr & hit_ctrl & data_in[CTRL_START];
   assign abort_req = wr & hit_ctrl & data_in[CTRL_ABORT];
   assign err_set   = busy & ((wr & (hit_base | hit_exp | hit_mod))
                    | (start_req & ~abort_req));

   modexp_wide_reg_bank #(.OPW(OPW), .DW(DW)) u_base (
      .clk(clk), .rst(rst), .we_i(bank_wr & hit_base),
      .word_i(wsel), .sel_i(sel), .wdata_i(data_in),
      .rdata_o(base_rd), .value_o(core_base)
   );

   modexp_wide_reg_bank #(.OPW(OPW), .DW(DW)) u_exp (
      .clk(clk), .rst(rst), .we_i(bank_wr & hit_exp),
      .word_i(wsel), .sel_i(sel), .wdata_i(data_in),
      .rdata_o(exp_rd), .value_o(core_exp)
   );

   modexp_wide_reg_bank #(.OPW(OPW), .DW(DW)) u_mod (
      .clk(clk), .rst(rst), .we_i(bank_wr & hit_mod),
      .word_i(wsel), .sel_i(sel), .wdata_i(data_in),
      .rdata_o(mod_rd), .value_o(core_mod)
   );

   // Sequencer: start pulse, wait for done, or abort
   always_comb begin
      state_d    = state_q;
      go         = 1'b0;
      capture    = 1'b0;
      abort_fire = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_req && !abort_req) begin
               state_d = ST_START;
               go      = 1'b1;
            end
         end
         ST_START, ST_RUN: begin
            if (core_done) begin
               capture = 1'b1;
               state_d = ST_IDLE;
            end else if (abort_req) begin
               abort_fire = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sticky status, irq enable and read mux
   always_comb begin
      done_d = done_q;
      err_d  = err_q;
      if (wr && hit_stat && data_in[STAT_DONE]) done_d = 1'b0;
      if (wr && hit_stat && data_in[STAT_ERR])  err_d  = 1'b0;
      if (go)      done_d = 1'b0;
      if (capture) done_d = 1'b1;
      if (err_set) err_d  = 1'b1;

      irqen_d = irqen_q;
      if (wr && hit_irqen && sel[0]) irqen_d = data_in[2:0];

      irq_d = (done_q & irqen_q[IRQ_DONE]) | (err_q & irqen_q[IRQ_ERR]);

      rd_word = '0;
      unique case (1'b1)
         hit_base:  rd_word = base_rd;
         hit_exp:   rd_word = exp_rd;
         hit_mod:   rd_word = mod_rd;
         hit_res:   rd_word = result_q[int'(wsel) * DW +: DW];
         hit_stat:  rd_word = DW'({irq_q, err_q, done_q, busy});
         hit_irqen: rd_word = DW'(irqen_q);
         default:   rd_word = '0;
      endcase

      data_out_d = data_out_q;
      if (acc && !we) data_out_d = rd_word;
   end

   // State and register updates
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         result_q   <= '0;
         data_out_q <= '0;
         ack_q      <= 1'b0;
         irq_q      <= 1'b0;
         abort_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         irqen_q    <= '0;
      end else begin
         state_q    <= state_d;
         if (capture) result_q <= core_result;
         data_out_q <= data_out_d;
         ack_q      <= acc;
         irq_q      <= irq_d;
         abort_q    <= abort_fire;
         done_q     <= done_d;
         err_q      <= err_d;
         irqen_q    <= irqen_d;
      end
   end

   assign data_out   = data_out_q;
   assign ack        = ack_q;
   assign irq        = irq_q;
   assign core_start = (state_q == ST_START);
   assign core_abort = abort_q;

endmodule

// File: tb/tb_modexp_wb_regs_narrow.sv
// Directed bench for modexp_wb_regs_narrow with a small
// behavioural modexp core model.
module tb_modexp_wb_regs_narrow;

   localparam int OPW = 128;
   localparam int DW  = 32;
   localparam int AW  = 5;

   logic             clk = 1'b0;
   logic             rst, cyc, stb, we;
   logic [AW-1:0]    addr;
   logic [3:0]       sel;
   logic [DW-1:0]    data_in, data_out;
   logic             ack, irq;
   logic [OPW-1:0]   core_base, core_exp, core_mod, core_result;
   logic             core_start, core_abort, core_done;

   int checks = 0;
   int errors = 0;
   int starts = 0;
   int aborts = 0;
   int lat    = 8;
   int cnt    = 0;
   logic [31:0] res_pend = '0;
   logic [31:0] q;
   int n;

   always #5 clk = ~clk;

   modexp_wb_regs_narrow #(.OPW(OPW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we),
      .addr(addr), .sel(sel), .data_in(data_in),
      .data_out(data_out), .ack(ack), .irq(irq),
      .core_base(core_base), .core_exp(core_exp),
      .core_mod(core_mod), .core_start(core_start),
      .core_abort(core_abort), .core_result(core_result),
      .core_done(core_done)
   );

   function automatic logic [31:0] modexp(input logic [31:0] b,
                                          input logic [31:0] e,
                                          input logic [31:0] m);
      logic [63:0] r, x;
      if (m == 0) return 32'd0;
      r = 64'd1 % 64'(m);
      x = 64'(b) % 64'(m);
      for (int i = 0; i < 32; i++) begin
         if (e[i]) r = (r * x) % 64'(m);
         x = (x * x) % 64'(m);
      end
      return r[31:0];
   endfunction

   // Core model: fixed latency, keeps running after an abort
   always begin
      @(posedge clk); #1;
      core_done = 1'b0;
      if (rst) begin
         cnt = 0;
      end else begin
         if (core_abort) aborts++;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               core_done   = 1'b1;
               core_result = {96'd0, res_pend};
            end
         end
         if (core_start) begin
            starts++;
            cnt = lat;
            res_pend = modexp(core_base[31:0], core_exp[31:0],
                              core_mod[31:0]);
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic xfer(input logic w, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rq);
      int k;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w;
      addr = a; data_in = d; sel = s;
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!ack && k < 8);
      check("ack", 64'(ack), 64'd1);
      rq  = data_out;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d,
                     input logic [3:0] s = 4'hF);
      logic [31:0] dummy;
      xfer(1'b1, a, d, s, dummy);
   endtask

   task automatic rd(input logic [AW-1:0] a, output logic [31:0] rq);
      xfer(1'b0, a, 32'd0, 4'h0, rq);
   endtask

   task automatic wait_done(output logic [31:0] st);
      int k;
      k = 0;
      do begin
         rd(5'd17, st);
         k++;
      end while (!st[1] && k < 100);
      check("done_wait", 64'(st[1]), 64'd1);
   endtask

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      addr = '0; sel = '0; data_in = '0;
      core_done = 1'b0; core_result = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctl", 64'({ack, irq, core_start, core_abort}), 64'd0);
      check("rst_dout", 64'(data_out), 64'd0);
      rst = 1'b0;
      rd(5'd17, q);
      check("stat_rst", 64'(q), 64'd0);

      wr(5'd0, 32'd4);
      wr(5'd4, 32'd13);
      wr(5'd8, 32'd497);
      check("core_base", core_base[63:0], 64'd4);
      check("core_exp", core_exp[63:0], 64'd13);
      check("core_mod", core_mod[63:0], 64'd497);
      wr(5'd16, 32'd1);
      wait_done(q);
      rd(5'd12, q);
      check("result0", 64'(q), 64'd445);
      rd(5'd17, q);
      check("stat_done", 64'(q), 64'h2);
      rd(5'd16, q);
      check("ctrl_rd", 64'(q), 64'd0);
      check("starts1", 64'(starts), 64'd1);

      wr(5'd17, 32'h2);
      rd(5'd17, q);
      check("w1c_done", 64'(q), 64'd0);
      wr(5'd18, 32'd1);
      wr(5'd16, 32'd1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!core_done && n < 50);
      check("core_done_seen", 64'(core_done), 64'd1);
      @(posedge clk); #1;
      check("irq_lag", 64'(irq), 64'd0);
      @(posedge clk); #1;
      check("irq_set", 64'(irq), 64'd1);
      wr(5'd17, 32'h2);
      @(posedge clk); #1;
      check("irq_clr", 64'(irq), 64'd0);
      rd(5'd17, q);
      check("stat_clr", 64'(q), 64'd0);

      lat = 40;
      wr(5'd16, 32'd1);
      wr(5'd4, 32'hFFFF_FFFF);
      rd(5'd4, q);
      check("exp_prot", 64'(q), 64'd13);
      rd(5'd17, q);
      check("stat_busy_err", 64'(q), 64'h5);
      wr(5'd16, 32'd1);
      wait_done(q);
      rd(5'd17, q);
      check("stat_err_done", 64'(q), 64'hE);
      check("starts3", 64'(starts), 64'd3);
      check("core_exp_kept", core_exp[63:0], 64'd13);
      wr(5'd17, 32'h6);
      rd(5'd17, q);
      check("w1c_both", 64'(q), 64'd0);

      lat = 20;
      wr(5'd0, 32'd5);
      wr(5'd16, 32'd1);
      wr(5'd16, 32'd2);
      rd(5'd17, q);
      check("stat_abort", 64'(q), 64'd0);
      check("aborts1", 64'(aborts), 64'd1);
      repeat (30) @(posedge clk);
      #1;
      rd(5'd12, q);
      check("result_kept", 64'(q), 64'd445);
      rd(5'd17, q);
      check("stat_late_done", 64'(q), 64'd0);
      check("starts4", 64'(starts), 64'd4);

      wr(5'd16, 32'd2);
      wr(5'd16, 32'd3);
      rd(5'd17, q);
      check("stat_idle_abort", 64'(q), 64'd0);
      check("aborts_idle", 64'(aborts), 64'd1);
      check("starts_sa", 64'(starts), 64'd4);

      wr(5'd1, 32'h1122_3344);
      wr(5'd1, 32'h00AB_0000, 4'b0100);
      rd(5'd1, q);
      check("byte_lane", 64'(q), 64'h11AB_3344);
      rd(5'd20, q);
      check("unmapped_rd", 64'(q), 64'd0);
      wr(5'd20, 32'hFFFF_FFFF);
      rd(5'd0, q);
      check("unmapped_wr", 64'(q), 64'd5);
      wr(5'd18, 32'd7, 4'h0);
      rd(5'd18, q);
      check("irqen_nosel", 64'(q), 64'd1);
      wr(5'd18, 32'd5);
      rd(5'd18, q);
      check("irqen_rd", 64'(q), 64'd5);
      wr(5'd18, 32'd0);

      lat = 30;
      wr(5'd0, 32'd4);
      wr(5'd16, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("rrun_ctl", 64'({ack, irq, core_start, core_abort}), 64'd0);
      check("rrun_dout", 64'(data_out), 64'd0);
      check("rrun_banks", 64'(|{core_base, core_exp, core_mod}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      rd(5'd17, q);
      check("rrun_stat", 64'(q), 64'd0);
      rd(5'd12, q);
      check("rrun_result", 64'(q), 64'd0);

      lat = 8;
      wr(5'd0, 32'd4);
      wr(5'd4, 32'd13);
      wr(5'd8, 32'd497);
      wr(5'd16, 32'd1);
      wait_done(q);
      rd(5'd12, q);
      check("result_after_rst", 64'(q), 64'd445);
      rd(5'd17, q);
      check("stat_after_rst", 64'(q), 64'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
